pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
- Sequencer for the serial pattern-detection datapath: accepts a WIDTH-bit word plus a runtime-programmable pattern, then feeds the word MSB-first, one bit per clock, through an internal overlapping-match detector.
- Counts matches, records the stream position of the first match, and reports completion with a start/busy/done handshake.
- Sits between a host/register interface and the serial detector, so software scans whole words instead of driving x bit by bit.

Parameters:
- WIDTH, 32, bits per scanned word (>= 2).
- PMAX, 8, maximum pattern length in bits (2..16).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- abort  input  1  cancel an in-progress scan; honoured only in SCAN.
- data_in  input  WIDTH  word to scan; bit WIDTH-1 is streamed first.
- pattern  input  PMAX  pattern, right-justified; bit 0 = most recent bit of the match.
- pat_len  input  $clog2(PMAX+1)  pattern length in bits.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse in DONE.
- x_out  output  1  bit currently being scanned (debug/monitor).
- z  output  1  Mealy match strobe for the current bit.
- match_count  output  $clog2(WIDTH+1)  number of matches in the last scan.
- found  output  1  at least one match in the last scan.
- first_pos  output  $clog2(WIDTH)  stream index k (0 = first bit sent) of the final bit of the first match.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE. busy, done, z, x_out, match_count, found and first_pos are all 0. Internal shift word, window and bit counter are 0.
- States: IDLE, SCAN, DONE (binary encoded).
- IDLE + start=1 at an edge:
  - Capture data_in, pattern and the effective length L.
  - Clear window, bit counter k, match_count, found and first_pos.
  - Next state = SCAN.
- Effective length L:
  - L = pat_len, saturated to PMAX.
  - pat_len = 0 means no matches are possible; the scan still runs to DONE.
- SCAN cycle k (k = 0..WIDTH-1):
  - x_out = captured bit WIDTH-1-k.
  - cand = {window[PMAX-2:0], x_out}.
  - z = 1 combinationally when L != 0, k+1 >= L, and cand[L-1:0] == pattern[L-1:0].
  - Matches overlap: the window is never flushed on a match.
- At the SCAN edge:
  - window <= cand; k <= k+1.
  - If z: match_count increments. If found=0, set found=1 and first_pos <= k.
  - After k = WIDTH-1, next state = DONE.
- Timing: busy=1 for exactly WIDTH cycles. DONE lasts 1 cycle (done=1, busy=0), then IDLE. Start-edge to done-pulse latency is WIDTH+1 cycles.
- start is ignored in SCAN and DONE. There is no queuing: a request made while busy is lost.
- abort=1 in SCAN: next state = IDLE with no done pulse. match_count, found and first_pos keep their partial values. A match on the abort cycle is still counted, because abort takes priority only over the state transition.
- abort outside SCAN: ignored.
- abort and the last bit on the same cycle: go to IDLE, no done pulse.
- Results hold stable from DONE until the next accepted start.
- Outside SCAN, z=0 and x_out=0.
- Reset mid-scan: immediate return to reset values; no done pulse.
- match_count cannot overflow, since at most WIDTH-1 matches are possible with L >= 2.

Test Plan:
- Scenario 1: WIDTH=32, data_in=32'b11001101010011001001101011001010, pattern=3'b101, pat_len=3, start for 1 cycle -> busy high 32 cycles; z pulses at k=7,9,22,24,30; done pulse in cycle 33; match_count=5, found=1, first_pos=7.
- Scenario 2: data_in=32'hFFFFFFFF, pattern=2'b11, pat_len=2 -> z high for k=1..31; match_count=31, first_pos=1.
- Scenario 3: data_in=32'h00000000, pattern=101, pat_len=3 -> no z; match_count=0, found=0, first_pos=0; done still pulses after 33 cycles.
- Scenario 4: scenario 1 stimulus with abort=1 at k=10 -> IDLE next cycle, no done; match_count=2, first_pos=7. start asserted during SCAN and during DONE is ignored (busy not re-extended).
- Scenario 5: pat_len=0, then pat_len=15 with PMAX=8, pattern=8'hA5, data_in=32'h00A5A500 -> first run: 0 matches. Second run, saturated to L=8: matches at k=15 and k=23, count=2.
- Scenario 6: clear asserted asynchronously mid-clock at k=12 -> all outputs 0 immediately; no done. A fresh start then rescans scenario 1 with identical results.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Word-level sequencer around an overlapping serial pattern detector.
// Streams a captured word MSB-first and tallies matches per scan.
module pattern_scan_ctrl #(
  parameter int WIDTH = 32,
  parameter int PMAX  = 8,
  localparam int LW = $clog2(PMAX+1),
  localparam int CW = $clog2(WIDTH+1),
  localparam int KW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic [PMAX-1:0]  pattern,
  input  logic [LW-1:0]    pat_len,
  output logic          busy,
  output logic          done,
  output logic          x_out,
  output logic          z,
  output logic [CW-1:0] match_count,
  output logic          found,
  output logic [KW-1:0] first_pos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] word_q;
  logic [PMAX-1:0]  pat_q;
  logic [LW-1:0]    len_q;
  logic [PMAX-1:0]  win_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    count_q;
  logic             found_q;
  logic [KW-1:0]    first_q;

  logic [LW-1:0]    len_eff;
  logic [PMAX-1:0]  cand;
  logic [PMAX-1:0]  mask;
  logic             x_bit;
  logic             hit;
  logic             last;
  logic             scanning;
  logic             accept;

  assign scanning = (state == SCAN);
  assign accept   = (state == IDLE) && start;
  assign last     = (k_q == KW'(WIDTH-1));

  // Lengths beyond the window saturate rather than wrap.
  assign len_eff = (pat_len > LW'(PMAX)) ? LW'(PMAX) : pat_len;

  assign x_bit = scanning ? word_q[WIDTH-1] : 1'b0;
  assign cand  = {win_q[PMAX-2:0], x_bit};

  always_comb begin
    mask = '0;
    for (int i = 0; i < PMAX; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // Early bits cannot complete a match until L bits have arrived.
  always_comb begin
    hit = 1'b0;
    if (scanning && (len_q != '0)) begin
      if ((int'(k_q) + 1) >= int'(len_q)) begin
        hit = (((cand ^ pat_q) & mask) == '0);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      word_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      win_q   <= '0;
      k_q     <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else if (accept) begin
      word_q  <= data_in;
      pat_q   <= pattern;
      len_q   <= len_eff;
      win_q   <= '0;
      k_q     <= '0;
      count_q <= '0;
      found_q <= 1'b0;
      first_q <= '0;
    end else if (scanning) begin
      word_q <= word_q << 1;
      win_q  <= cand;
      k_q    <= last ? '0 : k_q + KW'(1);
      // A match on an abort cycle still counts.
      if (hit) begin
        count_q <= count_q + CW'(1);
        if (!found_q) begin
          found_q <= 1'b1;
          first_q <= k_q;
        end
      end
    end
  end

  assign busy        = scanning;
  assign done        = (state == DONE);
  assign x_out       = x_bit;
  assign z           = hit;
  assign match_count = count_q;
  assign found       = found_q;
  assign first_pos   = first_q;

endmodule
